// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: register/data widths, the fixed
// link and zero register indices, the queued-item record and a register-mask helper.
package writeback_arbiter_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** REG_W;

    localparam logic [REG_W-1:0] LINK_REG = 5'd1;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_item_t;

    // One-hot mask for a destination register; register 0 never shows as pending.
    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != REG_ZERO) m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Circular load-return FIFO for the writeback arbiter.
// With WB_SCOREBOARD_EN defined it also reports which registers its live entries target.
module wb_load_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  wb_item_t                 push_item,
    input  logic                     pop,
    output wb_item_t                 head_item,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(LD_DEPTH):0] count,
    output logic [NUM_REGS-1:0]      reg_mask
);

    localparam int PTR_W = $clog2(LD_DEPTH);

    wb_item_t         mem [LD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (PTR_W+1)'(LD_DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_item = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_item;
    end

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        logic [PTR_W-1:0] offs;
        reg_mask = '0;
        offs     = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if ({1'b0, offs} < count) reg_mask = reg_mask | reg_bit(mem[i].rd);
        end
    end
`else
    assign reg_mask = '0;
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Register-bank writeback arbiter: link > ALU skid > ALU handshake > load FIFO.
// Define WB_SCOREBOARD_EN to drive the per-register pending mask.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      Jal,
    input  logic [DATA_W-1:0]         PC,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_W-1:0]          alu_reg,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [REG_W-1:0]          ld_reg,
    input  logic [DATA_W-1:0]         ld_data,
    output logic                      RegWrite,
    output logic [REG_W-1:0]          WriteRegister,
    output logic [DATA_W-1:0]         WriteData,
    output logic [$clog2(LD_DEPTH):0] ld_count,
    output logic [NUM_REGS-1:0]       pending
);

    logic                skid_valid;
    wb_item_t            skid_item;
    logic                alu_hs;
    logic                ld_push;
    logic                ld_pop;
    logic                fifo_full;
    logic                fifo_empty;
    wb_item_t            head_item;
    wb_item_t            issue_item;
    logic                issue_valid;
    logic [NUM_REGS-1:0] fifo_mask;
    logic [NUM_REGS-1:0] skid_mask;

    assign alu_ready = !skid_valid;
    assign alu_hs    = alu_valid && alu_ready;
    assign ld_ready  = !fifo_full;
    assign ld_push   = ld_valid && ld_ready;

    wb_load_fifo #(.LD_DEPTH(LD_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ld_push),
        .push_item ('{rd: ld_reg, data: ld_data}),
        .pop       (ld_pop),
        .head_item (head_item),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (ld_count),
        .reg_mask  (fifo_mask)
    );

    // The FIFO is only popped when nothing of higher priority wants the port.
    always_comb begin
        issue_valid = 1'b1;
        issue_item  = head_item;
        ld_pop      = 1'b0;
        if (Jal)              issue_item = '{rd: LINK_REG, data: PC + 32'd1};
        else if (skid_valid)  issue_item = skid_item;
        else if (alu_hs)      issue_item = '{rd: alu_reg, data: alu_data};
        else if (!fifo_empty) ld_pop = 1'b1;
        else                  issue_valid = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            skid_valid    <= 1'b0;
            skid_item     <= '0;
        end else begin
            RegWrite <= issue_valid && (issue_item.rd != REG_ZERO);
            if (issue_valid) begin
                WriteRegister <= issue_item.rd;
                WriteData     <= issue_item.data;
            end
            // An ALU result that loses to the link waits in the skid.
            if (Jal && alu_hs) begin
                skid_valid <= 1'b1;
                skid_item  <= '{rd: alu_reg, data: alu_data};
            end else if (!Jal) begin
                skid_valid <= 1'b0;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    assign skid_mask = skid_valid ? reg_bit(skid_item.rd) : '0;
`else
    assign skid_mask = '0;
`endif

    assign pending = fifo_mask | skid_mask;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: table vectors plus multi-cycle sequences,
// with every issued write checked in order against a queue of expected writes.
module tb_writeback_arbiter;

    import writeback_arbiter_pkg::*;

    localparam int LD_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        Jal;
    logic [31:0] PC;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [2:0]  ld_count;
    logic [31:0] pending;

    always #5 clock = ~clock;

    writeback_arbiter #(.LD_DEPTH(LD_DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .Jal           (Jal),
        .PC            (PC),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_reg        (ld_reg),
        .ld_data       (ld_data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ld_count      (ld_count),
        .pending       (pending)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic        jal;
        logic [31:0] pc;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        exp_rw;
        logic        chk;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    sb_t  exp_q[$];
    sb_t  mon_item;
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
        sb_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic jal, input logic [31:0] pc,
                                 input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
        Jal       = jal;
        PC        = pc;
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        ld_valid  = lv;
        ld_reg    = lr;
        ld_data   = ldd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every RegWrite pulse must match the oldest outstanding expected write.
    always @(negedge clock) begin
        if (reset === 1'b0 && RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_write: got reg %0d data %h, expected no write", WriteRegister, WriteData);
            end else begin
                mon_item = exp_q.pop_front();
                checkOutput("sb_reg", 32'(WriteRegister), 32'(mon_item.rd));
                checkOutput("sb_data", WriteData, mon_item.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] exp_pend;

        vecs[0] = '{1'b1, 32'h0000_0040, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 5'd1,  32'h0000_0041};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 5'd1,  32'h0000_0000};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 5'd3,  32'h0000_1234, 1'b1, 1'b1, 5'd3,  32'h0000_1234};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd31, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 5'd31, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0,  32'h0};

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        checkOutput("reset_RegWrite", RegWrite, 0);
        checkOutput("reset_WriteRegister", WriteRegister, 0);
        checkOutput("reset_WriteData", WriteData, 0);
        checkOutput("reset_ld_count", ld_count, 0);
        checkOutput("reset_pending", pending, 0);
        checkOutput("reset_alu_ready", alu_ready, 1);
        checkOutput("reset_ld_ready", ld_ready, 1);
        reset = 1'b0;
        tick();

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].jal, vecs[i].pc, vecs[i].av, vecs[i].ar, vecs[i].ad, 0, 0, 0);
            if (vecs[i].exp_rw) expectWrite(vecs[i].exp_reg, vecs[i].exp_data);
            tick();
            checkOutput($sformatf("vec%0d_RegWrite", i), RegWrite, vecs[i].exp_rw);
            if (vecs[i].chk) begin
                checkOutput($sformatf("vec%0d_WriteRegister", i), WriteRegister, vecs[i].exp_reg);
                checkOutput($sformatf("vec%0d_WriteData", i), WriteData, vecs[i].exp_data);
            end
            checkOutput($sformatf("vec%0d_alu_ready", i), alu_ready, 1);
        end

        $display("[TB] link collides with ALU handshake");
        applyStimulus(1, 32'h0000_0100, 1, 5'd5, 32'd7, 0, 0, 0);
        expectWrite(LINK_REG, 32'h0000_0101);
        expectWrite(5'd5, 32'd7);
        tick();
        checkOutput("collide_link_RegWrite", RegWrite, 1);
        checkOutput("collide_link_reg", WriteRegister, 1);
        checkOutput("collide_link_data", WriteData, 32'h0000_0101);
        checkOutput("collide_alu_ready_low", alu_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("collide_skid_RegWrite", RegWrite, 1);
        checkOutput("collide_skid_reg", WriteRegister, 5);
        checkOutput("collide_skid_data", WriteData, 7);
        checkOutput("collide_alu_ready_high", alu_ready, 1);
        tick();
        checkOutput("collide_idle_RegWrite", RegWrite, 0);

        $display("[TB] fill load FIFO under link");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h0000_0200, 0, 0, 0, 1, 5'(10 + i), 32'(32'hA0 + i));
            expectWrite(LINK_REG, 32'h0000_0201);
            tick();
        end
        checkOutput("fill_ld_count", ld_count, 4);
        checkOutput("fill_ld_ready", ld_ready, 0);
        for (int i = 0; i < 4; i++) expectWrite(5'(10 + i), 32'(32'hA0 + i));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("drain0_RegWrite", RegWrite, 1);
        checkOutput("drain0_reg", WriteRegister, 10);
        checkOutput("drain0_ld_count", ld_count, 3);
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd14, 32'h0000_00B4);
        expectWrite(5'd14, 32'h0000_00B4);
        tick();
        checkOutput("drain1_reg", WriteRegister, 11);
        checkOutput("pushpop_ld_count", ld_count, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i < 5; i++) begin
            tick();
            checkOutput($sformatf("drain%0d_RegWrite", i), RegWrite, 1);
            checkOutput($sformatf("drain%0d_reg", i), WriteRegister, 32'(10 + i));
            checkOutput($sformatf("drain%0d_ld_count", i), ld_count, 32'(4 - i));
        end
        tick();
        checkOutput("drained_RegWrite", RegWrite, 0);

        $display("[TB] minimum load latency");
        applyStimulus(0, 0, 0, 0, 0, 1, 5'd20, 32'h5555_AAAA);
        expectWrite(5'd20, 32'h5555_AAAA);
        tick();
        checkOutput("latency_push_RegWrite", RegWrite, 0);
        checkOutput("latency_push_ld_count", ld_count, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("latency_pop_RegWrite", RegWrite, 1);
        checkOutput("latency_pop_reg", WriteRegister, 20);
        checkOutput("latency_pop_ld_count", ld_count, 0);

        $display("[TB] pending mask");
        applyStimulus(1, 32'h0000_0300, 0, 0, 0, 1, 5'd9, 32'h0000_0099);
        expectWrite(LINK_REG, 32'h0000_0301);
        expectWrite(5'd9, 32'h0000_0099);
        tick();
`ifdef WB_SCOREBOARD_EN
        exp_pend = 32'h0000_0200;
`else
        exp_pend = 32'h0;
`endif
        checkOutput("pending_load_queued", pending, exp_pend);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pending_load_reg", WriteRegister, 9);
        checkOutput("pending_load_cleared", pending, 0);
        applyStimulus(1, 32'h0000_0400, 1, 5'd6, 32'h0000_0066, 0, 0, 0);
        expectWrite(LINK_REG, 32'h0000_0401);
        expectWrite(5'd6, 32'h0000_0066);
        tick();
`ifdef WB_SCOREBOARD_EN
        exp_pend = 32'h0000_0040;
`else
        exp_pend = 32'h0;
`endif
        checkOutput("pending_skid_held", pending, exp_pend);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pending_skid_reg", WriteRegister, 6);
        checkOutput("pending_skid_cleared", pending, 0);

        $display("[TB] reset with loads queued");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h0000_0500, 0, 0, 0, 1, 5'(21 + i), 32'(32'hC0 + i));
            expectWrite(LINK_REG, 32'h0000_0501);
            tick();
        end
        checkOutput("prereset_ld_count", ld_count, 3);
        @(negedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("midreset_ld_count", ld_count, 0);
        checkOutput("midreset_pending", pending, 0);
        checkOutput("midreset_RegWrite", RegWrite, 0);
        checkOutput("midreset_ld_ready", ld_ready, 1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("postreset%0d_RegWrite", i), RegWrite, 0);
        end
        checkOutput("postreset_ld_count", ld_count, 0);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
